// File: rtl/rf_dump_pkg.sv
// Shared types and constants for the register-file dump unit.
package rf_dump_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        FINISH
    } dump_state_t;

    localparam logic [5:0] CHECKSUM_INDEX = 6'd32;

endpackage

// File: rtl/reg_dump_unit.sv
// Streams register-file entries FIRST_REG..LAST_REG as valid/ready beats.
// Optional trailing XOR checksum beat when DUMP_CHECKSUM_EN is defined.
module reg_dump_unit
    import rf_dump_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        wr_block,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_index,
    output logic [31:0] out_data
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    dump_state_t state;
    logic [4:0]  idx;
    logic        last_beat;

`ifdef DUMP_CHECKSUM_EN
    logic [31:0] checksum;
    logic        ck_beat;

    // The checksum beat, not the last register beat, closes the dump.
    assign last_beat = ck_beat;
`else
    assign last_beat = (idx == LAST_IDX);
`endif

    assign rf_addr  = idx;
    assign wr_block = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= FIRST_IDX;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
`ifdef DUMP_CHECKSUM_EN
            checksum  <= '0;
            ck_beat   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= FIRST_IDX;
                        busy  <= 1'b1;
                        state <= READ;
`ifdef DUMP_CHECKSUM_EN
                        checksum <= '0;
                        ck_beat  <= 1'b0;
`endif
                    end
                end
                READ: begin
                    out_data  <= rf_data;
                    out_index <= {1'b0, idx};
                    out_valid <= 1'b1;
                    state     <= SEND;
`ifdef DUMP_CHECKSUM_EN
                    checksum  <= checksum ^ rf_data;
`endif
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        if (last_beat) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= FINISH;
                        end else if (idx < LAST_IDX) begin
                            idx       <= idx + 5'd1;
                            out_valid <= 1'b0;
                            state     <= READ;
                        end
`ifdef DUMP_CHECKSUM_EN
                        else begin
                            // out_valid stays high straight into the checksum beat.
                            ck_beat   <= 1'b1;
                            out_data  <= checksum;
                            out_index <= CHECKSUM_INDEX;
                        end
`endif
                    end
                end
                FINISH: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: full dump, stalls, restart, reset, narrow ranges.
module tb_reg_dump_unit;

`ifdef DUMP_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [2:0]  start;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  wr_block;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [4:0]  rf_addr   [3];
    logic [31:0] rf_data   [3];
    logic [5:0]  out_index [3];
    logic [31:0] out_data  [3];
    logic [31:0] regs      [32];

    int n_total = 0;
    int n_bad   = 0;

    reg_dump_unit d0 (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .wr_block(wr_block[0]), .rf_addr(rf_addr[0]), .rf_data(rf_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_index(out_index[0]), .out_data(out_data[0])
    );

    reg_dump_unit #(.FIRST_REG(9), .LAST_REG(9)) d1 (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .wr_block(wr_block[1]), .rf_addr(rf_addr[1]), .rf_data(rf_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_index(out_index[1]), .out_data(out_data[1])
    );

    reg_dump_unit #(.FIRST_REG(6), .LAST_REG(9)) d2 (
        .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .wr_block(wr_block[2]), .rf_addr(rf_addr[2]), .rf_data(rf_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_index(out_index[2]), .out_data(out_data[2])
    );

    assign rf_data[0] = regs[rf_addr[0]];
    assign rf_data[1] = regs[rf_addr[1]];
    assign rf_data[2] = regs[rf_addr[2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_reg(input int i);
        if (i == 9) return 32'h20;
        if (i == 6) return 32'h40;
        return i * 32'h11;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input int k, input int first);
        check("rst_busy",  32'(busy[k]), 0);
        check("rst_done",  32'(done[k]), 0);
        check("rst_wrblk", 32'(wr_block[k]), 0);
        check("rst_valid", 32'(out_valid[k]), 0);
        check("rst_data",  out_data[k], 0);
        check("rst_index", 32'(out_index[k]), 0);
        check("rst_addr",  32'(rf_addr[k]), first);
    endtask

    // Drives one dump on instance k and checks every cycle against expected beats.
    task automatic run_dump(input int k, input int first, input int last,
                            input bit rnd, input bit restart);
        int e, nb, cyc, exp_beats, exp_addr;
        bit restarted, seen_done, pulse;
        logic [31:0] xr;
        e = first; nb = 0; xr = '0; restarted = 1'b0; seen_done = 1'b0;
        exp_beats = last - first + 1 + (CK ? 1 : 0);
        @(negedge clk);
        start[k] = 1'b1;
        out_ready[k] = 1'b0;
        @(negedge clk);
        start[k] = 1'b0;
        cyc = 1;
        while (!seen_done && cyc < 2000) begin
            pulse = restart && (nb == 5) && !restarted;
            start[k] = pulse;
            if (pulse) restarted = 1'b1;
            out_ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            exp_addr = (e > last) ? last : e;
            check("busy", 32'(busy[k]), 1);
            check("wr_block", 32'(wr_block[k]), 1);
            check("rf_addr", 32'(rf_addr[k]), exp_addr);
            if (done[k]) begin
                seen_done = 1'b1;
                check("done_valid", 32'(out_valid[k]), 0);
                check("done_beats", nb, exp_beats);
                if (!rnd)
                    check("done_cycle", cyc, 2 * (last - first + 1) + (CK ? 1 : 0) + 1);
            end else if (out_valid[k]) begin
                check("index", 32'(out_index[k]), (e > last) ? 32 : e);
                check("data", out_data[k], (e > last) ? xr : exp_reg(e));
                if (out_ready[k]) begin
                    if (e <= last) xr = xr ^ exp_reg(e);
                    nb++;
                    e++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(seen_done), 1);
        start[k] = 1'b0;
        out_ready[k] = 1'b0;
        check("post_done", 32'(done[k]), 0);
        check("post_busy", 32'(busy[k]), 0);
        repeat (6) @(negedge clk);
        check("no_second_done", 32'(done[k] | busy[k]), 0);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 32; i++) regs[i] = i * 32'h11;
        regs[9] = 32'h20;
        regs[6] = 32'h40;
        rst = 1'b1;
        start = '0;
        out_ready = '0;
        repeat (3) @(negedge clk);
        check_reset(0, 0);
        check_reset(1, 9);
        check_reset(2, 6);
        rst = 1'b0;

        run_dump(0, 0, 31, 1'b0, 1'b0);
        run_dump(0, 0, 31, 1'b1, 1'b0);
        run_dump(0, 0, 31, 1'b1, 1'b1);

        // Reset while stalled in SEND on index 12.
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (out_valid[0] && out_index[0] == 6'd12) begin
                out_ready[0] = 1'b0;
                found = 1'b1;
            end else begin
                out_ready[0] = 1'b1;
                @(negedge clk);
            end
        end
        check("reach12", 32'(found), 1);
        repeat (2) @(negedge clk);
        check("stall_valid", 32'(out_valid[0]), 1);
        check("stall_index", 32'(out_index[0]), 12);
        check("stall_data", out_data[0], 32'hCC);
        check("stall_addr", 32'(rf_addr[0]), 12);
        rst = 1'b1;
        @(negedge clk);
        check_reset(0, 0);
        rst = 1'b0;
        out_ready[0] = 1'b0;
        run_dump(0, 0, 31, 1'b0, 1'b0);

        run_dump(1, 9, 9, 1'b0, 1'b0);
        run_dump(2, 6, 9, 1'b1, 1'b0);
        run_dump(2, 6, 9, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
